// File: rtl/csi2_tx_pkt_ctrl.sv
// csi2_tx_pkt_ctrl: CSI-2 packet sequencer in the byte clock domain.
// It turns converter frame/line events into FS/FE short packets and
// pixel-line long packets. It also drives the D-PHY transmitter's
// HS-enable, strobes, header fields and payload stream.
// Ports:
//   byte_clk_i, rst_n_i          - clock, async active-low reset
//   fv_start_i, fv_end_i         - frame start/end pulses from the converter
//   txfr_req_i                   - converter has a line ready (level)
//   byte_en_i, byte_data_i       - converter payload beats
//   data_type_i                  - data type of the pending line
//   txfr_en_o                    - transfer enable back to the converter
//   c2d_ready_i, d_hs_rdy_i      - transmitter ready / data lanes in HS
//   ld_pyld_i                    - transmitter is loading payload
//   clk_hs_en_o, d_hs_en_o       - HS clock lane request / data lane pulse
//   sp_en_o, lp_en_o             - short / long packet strobes
//   dt_o, vc_o, wc_o             - packet header fields
//   byte_data_en_o, byte_data_o  - payload to the transmitter
//   err_o                        - timeout pulse
module csi2_tx_pkt_ctrl #(
  parameter logic [15:0] WC             = 16'd1920,
  parameter int unsigned BYTES_PER_BEAT = 8,
  parameter logic [1:0]  VC             = 2'd0,
  parameter int unsigned T_CLK_PRE      = 8,
  parameter int unsigned T_TRAIL        = 8,
  parameter logic [15:0] FRAME_CNT_MAX  = 16'd0,
  parameter int unsigned TIMEOUT        = 1023
) (
  input  logic        byte_clk_i,
  input  logic        rst_n_i,
  input  logic        fv_start_i,
  input  logic        fv_end_i,
  input  logic        txfr_req_i,
  input  logic        byte_en_i,
  input  logic [63:0] byte_data_i,
  input  logic [5:0]  data_type_i,
  output logic        txfr_en_o,
  input  logic        c2d_ready_i,
  input  logic        d_hs_rdy_i,
  input  logic        ld_pyld_i,
  output logic        clk_hs_en_o,
  output logic        d_hs_en_o,
  output logic        sp_en_o,
  output logic        lp_en_o,
  output logic [5:0]  dt_o,
  output logic [1:0]  vc_o,
  output logic [15:0] wc_o,
  output logic        byte_data_en_o,
  output logic [63:0] byte_data_o,
  output logic        err_o
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BCNT_W = 17;
  localparam logic [5:0]  DT_FS  = 6'h00;
  localparam logic [5:0]  DT_FE  = 6'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLK_PRE,
    S_WAIT_HS,
    S_SEL,
    S_WAIT_PYLD,
    S_STREAM,
    S_TRAIL
  } state_t;

  state_t             state;
  logic               fs_pend;
  logic               fe_pend;
  logic               lp_pend;
  logic [15:0]        frame_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [BCNT_W-1:0]  byte_cnt;

  logic               any_pend_c;
  logic               fs_clr_c;
  logic               fe_clr_c;
  logic               beat_c;
  logic [BCNT_W-1:0]  byte_cnt_nxt_c;
  logic               last_beat_c;
  logic               timeout_c;

  // Packet selection and stream bookkeeping
  always_comb begin
    any_pend_c     = fs_pend | fe_pend | lp_pend;
    fs_clr_c       = (state == S_SEL) && fs_pend;
    fe_clr_c       = (state == S_SEL) && !fs_pend && !lp_pend && fe_pend;
    beat_c         = byte_en_i & txfr_en_o;
    byte_cnt_nxt_c = byte_cnt + BCNT_W'(BYTES_PER_BEAT);
    last_beat_c    = byte_cnt_nxt_c >= {1'b0, WC};
    timeout_c      = cnt == CNT_W'(TIMEOUT - 1);
  end

  // Pending flags and frame counter; a new event wins over a same-cycle clear
  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fs_pend   <= 1'b0;
      fe_pend   <= 1'b0;
      lp_pend   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      fs_pend <= fv_start_i | (fs_pend & ~fs_clr_c);
      fe_pend <= fv_end_i | (fe_pend & ~fe_clr_c);
      // The request is a level held until served, so the flag is its registered copy
      lp_pend <= txfr_req_i;
      if (fv_start_i) begin
        if (FRAME_CNT_MAX == 16'd0) begin
          frame_cnt <= 16'd0;
        end else if (frame_cnt >= FRAME_CNT_MAX) begin
          frame_cnt <= 16'd1;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  // Sequencer with registered transmitter/converter controls
  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      cnt            <= '0;
      byte_cnt       <= '0;
      txfr_en_o      <= 1'b0;
      clk_hs_en_o    <= 1'b0;
      d_hs_en_o      <= 1'b0;
      sp_en_o        <= 1'b0;
      lp_en_o        <= 1'b0;
      dt_o           <= '0;
      vc_o           <= '0;
      wc_o           <= '0;
      byte_data_en_o <= 1'b0;
      byte_data_o    <= '0;
      err_o          <= 1'b0;
    end else begin
      d_hs_en_o      <= 1'b0;
      sp_en_o        <= 1'b0;
      lp_en_o        <= 1'b0;
      err_o          <= 1'b0;
      byte_data_en_o <= 1'b0;
      vc_o           <= VC;
      case (state)
        S_IDLE: begin
          if (c2d_ready_i && any_pend_c) begin
            clk_hs_en_o <= 1'b1;
            cnt         <= '0;
            state       <= S_CLK_PRE;
          end
        end
        S_CLK_PRE: begin
          if (cnt == CNT_W'(T_CLK_PRE - 1)) begin
            d_hs_en_o <= 1'b1;
            cnt       <= '0;
            state     <= S_WAIT_HS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_HS: begin
          if (d_hs_rdy_i) begin
            state <= S_SEL;
          end else if (timeout_c) begin
            err_o       <= 1'b1;
            clk_hs_en_o <= 1'b0;
            txfr_en_o   <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SEL: begin
          cnt <= '0;
          if (fs_pend) begin
            sp_en_o <= 1'b1;
            dt_o    <= DT_FS;
            wc_o    <= frame_cnt;
            state   <= S_TRAIL;
          end else if (lp_pend) begin
            lp_en_o <= 1'b1;
            dt_o    <= data_type_i;
            wc_o    <= WC;
            state   <= S_WAIT_PYLD;
          end else if (fe_pend) begin
            sp_en_o <= 1'b1;
            dt_o    <= DT_FE;
            wc_o    <= frame_cnt;
            state   <= S_TRAIL;
          end else begin
            // Line request withdrawn while bringing up HS: just close the burst
            state <= S_TRAIL;
          end
        end
        S_WAIT_PYLD: begin
          if (ld_pyld_i) begin
            txfr_en_o <= 1'b1;
            byte_cnt  <= '0;
            state     <= S_STREAM;
          end else if (timeout_c) begin
            err_o       <= 1'b1;
            clk_hs_en_o <= 1'b0;
            txfr_en_o   <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STREAM: begin
          if (beat_c) begin
            byte_data_en_o <= 1'b1;
            byte_data_o    <= byte_data_i;
            byte_cnt       <= byte_cnt_nxt_c;
            if (last_beat_c) begin
              txfr_en_o <= 1'b0;
              cnt       <= '0;
              state     <= S_TRAIL;
            end
          end
        end
        S_TRAIL: begin
          if (cnt == CNT_W'(T_TRAIL - 1)) begin
            cnt <= '0;
            if (c2d_ready_i && any_pend_c) begin
              d_hs_en_o <= 1'b1;
              state     <= S_WAIT_HS;
            end else begin
              clk_hs_en_o <= 1'b0;
              state       <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_tx_pkt_ctrl.sv
// Self-checking bench for csi2_tx_pkt_ctrl: expected packets and payload
// beats are queued as stimulus is driven and popped as the DUT emits them.
module tb_csi2_tx_pkt_ctrl;

  localparam int unsigned BEATS   = 240;
  localparam int SIG_CLK  = 0;
  localparam int SIG_DHS  = 1;
  localparam int SIG_STB  = 2;
  localparam int SIG_ERR  = 3;
  localparam int SIG_TXEN = 4;
  localparam int SIG_IDLE = 5;

  typedef struct packed {
    logic        is_long;
    logic [5:0]  dt;
    logic [15:0] wc;
  } pkt_t;

  logic        byte_clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        fv_start_i = 1'b0;
  logic        fv_end_i = 1'b0;
  logic        txfr_req_i = 1'b0;
  logic        byte_en_i = 1'b0;
  logic [63:0] byte_data_i = '0;
  logic [5:0]  data_type_i = '0;
  logic        txfr_en_o;
  logic        c2d_ready_i = 1'b0;
  logic        d_hs_rdy_i = 1'b0;
  logic        ld_pyld_i = 1'b0;
  logic        clk_hs_en_o;
  logic        d_hs_en_o;
  logic        sp_en_o;
  logic        lp_en_o;
  logic [5:0]  dt_o;
  logic [1:0]  vc_o;
  logic [15:0] wc_o;
  logic        byte_data_en_o;
  logic [63:0] byte_data_o;
  logic        err_o;

  int          errors = 0;
  int          checks = 0;
  int          model_fc = 0;
  pkt_t        exp_q[$];
  logic [63:0] data_q[$];
  logic        mon_en = 1'b0;
  logic        clk_dropped = 1'b0;

  csi2_tx_pkt_ctrl #(
    .WC(16'd1920), .BYTES_PER_BEAT(8), .VC(2'd0), .T_CLK_PRE(8),
    .T_TRAIL(8), .FRAME_CNT_MAX(16'd2), .TIMEOUT(1023)
  ) dut (
    .byte_clk_i(byte_clk_i), .rst_n_i(rst_n_i),
    .fv_start_i(fv_start_i), .fv_end_i(fv_end_i),
    .txfr_req_i(txfr_req_i), .byte_en_i(byte_en_i),
    .byte_data_i(byte_data_i), .data_type_i(data_type_i),
    .txfr_en_o(txfr_en_o), .c2d_ready_i(c2d_ready_i),
    .d_hs_rdy_i(d_hs_rdy_i), .ld_pyld_i(ld_pyld_i),
    .clk_hs_en_o(clk_hs_en_o), .d_hs_en_o(d_hs_en_o),
    .sp_en_o(sp_en_o), .lp_en_o(lp_en_o), .dt_o(dt_o), .vc_o(vc_o),
    .wc_o(wc_o), .byte_data_en_o(byte_data_en_o),
    .byte_data_o(byte_data_o), .err_o(err_o)
  );

  always #5 byte_clk_i = ~byte_clk_i;

  // Records any drop of the HS clock request while enabled
  always @(negedge byte_clk_i) begin
    if (mon_en && clk_hs_en_o !== 1'b1) clk_dropped = 1'b1;
  end

  function automatic logic sig_of(int sel);
    case (sel)
      SIG_CLK:  return clk_hs_en_o;
      SIG_DHS:  return d_hs_en_o;
      SIG_STB:  return sp_en_o | lp_en_o;
      SIG_ERR:  return err_o;
      SIG_TXEN: return txfr_en_o;
      SIG_IDLE: return !clk_hs_en_o;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge byte_clk_i);
      if (sig_of(sel) === 1'b1) begin
        got = 1'b1;
        cyc = i + 1;
        return;
      end
    end
  endtask

  task automatic pulse_fs();
    pkt_t p;
    @(negedge byte_clk_i);
    fv_start_i = 1'b1;
    model_fc = (model_fc == 2) ? 1 : model_fc + 1;
    p.is_long = 1'b0; p.dt = 6'h00; p.wc = 16'(model_fc);
    exp_q.push_back(p);
    @(negedge byte_clk_i);
    fv_start_i = 1'b0;
  endtask

  // Answers the data-lane HS request and captures the next packet strobe
  task automatic get_strobe(output bit ok, output pkt_t got_p);
    bit got;
    int cyc;
    ok = 1'b0;
    got_p = '0;
    wait_sig(SIG_DHS, 64, got, cyc);
    if (!got) return;
    d_hs_rdy_i = 1'b1;
    wait_sig(SIG_STB, 16, got, cyc);
    d_hs_rdy_i = 1'b0;
    if (!got) return;
    ok = 1'b1;
    got_p.is_long = lp_en_o;
    got_p.dt = dt_o;
    got_p.wc = wc_o;
  endtask

  // Streams one line with random gaps, checking each payload beat
  task automatic do_stream();
    logic        drove;
    logic [63:0] expd;
    int          beats;
    bit          got;
    int          cyc;
    beats = 0;
    drove = 1'b0;
    @(negedge byte_clk_i);
    ld_pyld_i = 1'b1;
    @(negedge byte_clk_i);
    ld_pyld_i = 1'b0;
    wait_sig(SIG_TXEN, 4, got, cyc);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL txfr_en_rise: txfr_en_o=%b, required 1 after ld_pyld_i", txfr_en_o);
      return;
    end
    for (int c = 0; c < 4 * BEATS; c++) begin
      checks++;
      if (drove) begin
        expd = data_q.pop_front();
        if (byte_data_en_o !== 1'b1 || byte_data_o !== expd) begin
          errors++;
          $display("FAIL stream_beat%0d: en=%b data=%h, required en=1 data=%h",
                   beats, byte_data_en_o, byte_data_o, expd);
        end
      end else if (byte_data_en_o !== 1'b0) begin
        errors++;
        $display("FAIL stream_gap: byte_data_en_o=%b, required 0", byte_data_en_o);
      end
      if (beats == BEATS || txfr_en_o !== 1'b1) break;
      if ($urandom_range(3) == 0) begin
        byte_en_i = 1'b0;
        drove = 1'b0;
      end else begin
        byte_en_i = 1'b1;
        byte_data_i = {$urandom, $urandom};
        data_q.push_back(byte_data_i);
        beats++;
        drove = 1'b1;
      end
      @(negedge byte_clk_i);
    end
    byte_en_i = 1'b0;
    checks++;
    if (beats != BEATS) begin
      errors++;
      $display("FAIL stream_beats: accepted %0d beats, required %0d", beats, BEATS);
    end
    checks++;
    if (txfr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL txfr_en_drop: txfr_en_o=%b after last beat, required 0", txfr_en_o);
    end
    // Beats after the enable drops must not reach the transmitter
    byte_en_i = 1'b1;
    byte_data_i = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge byte_clk_i);
      checks++;
      if (byte_data_en_o !== 1'b0) begin
        errors++;
        $display("FAIL late_beat: byte_data_en_o=%b, required 0", byte_data_en_o);
      end
    end
    byte_en_i = 1'b0;
  endtask

  task automatic test_reset();
    bit got;
    int cyc;
    repeat (3) @(negedge byte_clk_i);
    checks++;
    if ({clk_hs_en_o, d_hs_en_o, sp_en_o, lp_en_o, dt_o, vc_o, wc_o, byte_data_en_o,
         byte_data_o, err_o, txfr_en_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: clk_hs=%b d_hs=%b sp=%b lp=%b dt=%h wc=%h bde=%b err=%b txen=%b, required all 0",
               clk_hs_en_o, d_hs_en_o, sp_en_o, lp_en_o, dt_o, wc_o, byte_data_en_o, err_o, txfr_en_o);
    end
    rst_n_i = 1'b1;
    c2d_ready_i = 1'b1;
    wait_sig(SIG_CLK, 12, got, cyc);
    checks++;
    if (got) begin
      errors++;
      $display("FAIL reset_idle: clk_hs_en_o=1 with nothing pending, required 0");
    end
  endtask

  task automatic test_first_fs();
    bit got;
    int cyc;
    pkt_t e;
    pulse_fs();
    wait_sig(SIG_CLK, 8, got, cyc);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fs_clk_hs: clk_hs_en_o=%b, required 1", clk_hs_en_o);
    end
    wait_sig(SIG_DHS, 20, got, cyc);
    checks++;
    if (!got || cyc != 8) begin
      errors++;
      $display("FAIL fs_clk_pre: d_hs_en_o after %0d cycles (seen=%0d), required 8", cyc, got);
    end
    d_hs_rdy_i = 1'b1;
    @(negedge byte_clk_i);
    checks++;
    if (d_hs_en_o !== 1'b0) begin
      errors++;
      $display("FAIL fs_dhs_pulse: d_hs_en_o=%b one cycle later, required 0", d_hs_en_o);
    end
    wait_sig(SIG_STB, 8, got, cyc);
    d_hs_rdy_i = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!got || sp_en_o !== 1'b1 || lp_en_o !== 1'b0 || dt_o !== e.dt || wc_o !== e.wc || vc_o !== 2'd0) begin
      errors++;
      $display("FAIL fs_packet: sp=%b lp=%b dt=%h wc=%0d vc=%0d, required sp=1 lp=0 dt=%h wc=%0d vc=0",
               sp_en_o, lp_en_o, dt_o, wc_o, vc_o, e.dt, e.wc);
    end
    wait_sig(SIG_IDLE, 20, got, cyc);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fs_release: clk_hs_en_o=%b after trail, required 0", clk_hs_en_o);
    end
  endtask

  task automatic test_line();
    bit ok;
    bit got;
    int cyc;
    pkt_t g;
    pkt_t e;
    data_type_i = 6'h2B;
    txfr_req_i = 1'b1;
    exp_q.push_back(pkt_t'{1'b1, 6'h2B, 16'd1920});
    get_strobe(ok, g);
    txfr_req_i = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e || sp_en_o !== 1'b0) begin
      errors++;
      $display("FAIL line_packet: ok=%0d long=%b dt=%h wc=%0d, required long=1 dt=%h wc=%0d",
               ok, g.is_long, g.dt, g.wc, e.dt, e.wc);
    end
    checks++;
    if (txfr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL line_txen_early: txfr_en_o=%b before ld_pyld_i, required 0", txfr_en_o);
    end
    do_stream();
    wait_sig(SIG_IDLE, 20, got, cyc);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL line_release: clk_hs_en_o=%b, required 0", clk_hs_en_o);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit got;
    int cyc;
    pkt_t g;
    pkt_t e;
    @(negedge byte_clk_i);
    fv_end_i = 1'b1;
    txfr_req_i = 1'b1;
    data_type_i = 6'h1E;
    exp_q.push_back(pkt_t'{1'b1, 6'h1E, 16'd1920});
    exp_q.push_back(pkt_t'{1'b0, 6'h01, 16'(model_fc)});
    @(negedge byte_clk_i);
    fv_end_i = 1'b0;
    get_strobe(ok, g);
    txfr_req_i = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL b2b_first: ok=%0d long=%b dt=%h wc=%0d, required long=1 dt=%h wc=%0d",
               ok, g.is_long, g.dt, g.wc, e.dt, e.wc);
    end
    clk_dropped = 1'b0;
    mon_en = 1'b1;
    do_stream();
    get_strobe(ok, g);
    mon_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL b2b_fe: ok=%0d long=%b dt=%h wc=%0d, required long=0 dt=%h wc=%0d",
               ok, g.is_long, g.dt, g.wc, e.dt, e.wc);
    end
    checks++;
    if (clk_dropped !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clk_hold: clk_hs_en_o dropped between packets, required held high");
    end
    wait_sig(SIG_IDLE, 20, got, cyc);
  endtask

  task automatic test_frames();
    bit ok;
    bit got;
    int cyc;
    pkt_t g;
    pkt_t e;
    @(negedge byte_clk_i);
    rst_n_i = 1'b0;
    repeat (2) @(negedge byte_clk_i);
    rst_n_i = 1'b1;
    model_fc = 0;
    exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      pulse_fs();
      get_strobe(ok, g);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g !== e) begin
        errors++;
        $display("FAIL frame%0d_fs: ok=%0d long=%b dt=%h wc=%0d, required long=0 dt=%h wc=%0d",
                 f, ok, g.is_long, g.dt, g.wc, e.dt, e.wc);
      end
      wait_sig(SIG_IDLE, 20, got, cyc);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit got;
    int cyc;
    pkt_t g;
    pkt_t e;
    pulse_fs();
    wait_sig(SIG_DHS, 64, got, cyc);
    wait_sig(SIG_ERR, 1100, got, cyc);
    checks++;
    if (!got || cyc != 1023) begin
      errors++;
      $display("FAIL timeout_err: err_o after %0d cycles (seen=%0d), required 1023", cyc, got);
    end
    checks++;
    if (clk_hs_en_o !== 1'b0 || txfr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: clk_hs=%b txen=%b, required 0 0", clk_hs_en_o, txfr_en_o);
    end
    @(negedge byte_clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err_o=%b one cycle later, required 0", err_o);
    end
    get_strobe(ok, g);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL timeout_retry: ok=%0d long=%b dt=%h wc=%0d, required long=0 dt=%h wc=%0d",
               ok, g.is_long, g.dt, g.wc, e.dt, e.wc);
    end
    wait_sig(SIG_IDLE, 20, got, cyc);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit got;
    int cyc;
    pkt_t g;
    pkt_t e;
    data_type_i = 6'h24;
    txfr_req_i = 1'b1;
    exp_q.push_back(pkt_t'{1'b1, 6'h24, 16'd1920});
    get_strobe(ok, g);
    txfr_req_i = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e) begin
      errors++;
      $display("FAIL rstmid_packet: ok=%0d long=%b dt=%h wc=%0d, required long=1 dt=%h wc=%0d",
               ok, g.is_long, g.dt, g.wc, e.dt, e.wc);
    end
    @(negedge byte_clk_i);
    ld_pyld_i = 1'b1;
    @(negedge byte_clk_i);
    ld_pyld_i = 1'b0;
    wait_sig(SIG_TXEN, 4, got, cyc);
    byte_en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      byte_data_i = {$urandom, $urandom};
      @(negedge byte_clk_i);
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({clk_hs_en_o, d_hs_en_o, sp_en_o, lp_en_o, dt_o, vc_o, wc_o, byte_data_en_o,
         byte_data_o, err_o, txfr_en_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: clk_hs=%b bde=%b dt=%h wc=%h txen=%b, required all 0",
               clk_hs_en_o, byte_data_en_o, dt_o, wc_o, txfr_en_o);
    end
    byte_en_i = 1'b0;
    data_q.delete();
    repeat (2) @(negedge byte_clk_i);
    rst_n_i = 1'b1;
    wait_sig(SIG_CLK, 20, got, cyc);
    checks++;
    if (got) begin
      errors++;
      $display("FAIL rstmid_idle: clk_hs_en_o=1 after reset release, required 0");
    end
  endtask

  initial begin
    test_reset();
    test_first_fs();
    test_line();
    test_back_to_back();
    test_frames();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/csi2_tx_pkt_ctrl.md
Name: csi2_tx_pkt_ctrl

Overview:
Packet sequencer between the pixel-to-byte converter and the CSI-2 D-PHY transmitter, in the byte clock domain. It turns frame/line events and transfer requests from the converter into CSI-2 short packets (FS/FE) and long packets (pixel lines). It drives the transmitter's HS-enable, packet-enable, header and byte-data signals. It also gates the converter's byte stream through the transfer-enable handshake.

Parameters:
WC, 16'd1920, long-packet word count in bytes (bytes per line)
BYTES_PER_BEAT, 8, payload bytes per byte_en beat (64-bit bus)
VC, 2'd0, virtual channel for all packets
T_CLK_PRE, 8, cycles of clk_hs_en_o before d_hs_en_o
T_TRAIL, 8, cycles held in HS after the last packet before releasing clk_hs_en_o
FRAME_CNT_MAX, 16'd0, FS/FE frame number wrap value; 0 means frame number is always 0
TIMEOUT, 1023, maximum wait cycles for d_hs_rdy_i or ld_pyld_i

Ports:
byte_clk_i  in  1  byte clock, the single clock
rst_n_i  in  1  asynchronous active-low reset
fv_start_i  in  1  frame-start pulse from the converter
fv_end_i  in  1  frame-end pulse from the converter
txfr_req_i  in  1  converter has a line ready
byte_en_i  in  1  converter byte data valid
byte_data_i  in  64  converter byte data
data_type_i  in  6  CSI-2 data type of the line
txfr_en_o  out  1  transfer enable to the converter
c2d_ready_i  in  1  transmitter ready for the next packet
d_hs_rdy_i  in  1  transmitter data lanes are in HS
ld_pyld_i  in  1  transmitter is loading the payload
clk_hs_en_o  out  1  HS clock lane request
d_hs_en_o  out  1  HS data lane request (1-cycle pulse)
sp_en_o  out  1  short-packet strobe (1-cycle pulse)
lp_en_o  out  1  long-packet strobe (1-cycle pulse)
dt_o  out  6  packet data type
vc_o  out  2  virtual channel
wc_o  out  16  word count or frame number
byte_data_en_o  out  1  payload valid to the transmitter
byte_data_o  out  64  payload to the transmitter
err_o  out  1  timeout pulse (1 cycle)

Behaviour:
- Reset: every output is 0; state is IDLE; pending flags are cleared; frame counter is 0.
- Pending flags: fs_pend is set by fv_start_i; fe_pend is set by fv_end_i; lp_pend follows txfr_req_i level. Each flag is cleared when its packet strobe is issued. If set and clear occur in the same cycle, set wins.
- Frame counter: increments on each fv_start_i. It runs 1..FRAME_CNT_MAX, then wraps to 1. When FRAME_CNT_MAX=0 it stays at 0. wc_o for FS and FE carries the current value.
- States:
  - IDLE: when c2d_ready_i=1 and any flag is pending -> CLK_PRE. Set clk_hs_en_o=1 on that transition.
  - CLK_PRE: count T_CLK_PRE cycles, pulse d_hs_en_o -> WAIT_HS.
  - WAIT_HS: on d_hs_rdy_i=1 -> SEL.
  - SEL: priority is FS > long > FE.
    - FS: pulse sp_en_o with dt_o=6'h00 -> TRAIL.
    - FE: pulse sp_en_o with dt_o=6'h01 -> TRAIL.
    - Long: pulse lp_en_o with dt_o=data_type_i and wc_o=WC -> WAIT_PYLD.
  - WAIT_PYLD: on ld_pyld_i=1, set txfr_en_o=1 -> STREAM.
  - STREAM: byte_data_o and byte_data_en_o are byte_data_i and byte_en_i registered one cycle. A byte counter adds BYTES_PER_BEAT per beat. When the counter reaches WC or more, txfr_en_o drops the same cycle the last beat is accepted -> TRAIL. Beats that arrive after txfr_en_o is low are ignored.
  - TRAIL: count T_TRAIL cycles. Then, if c2d_ready_i=1 and a flag is pending, pulse d_hs_en_o -> WAIT_HS (clk_hs_en_o stays high). Otherwise drop clk_hs_en_o -> IDLE.
- vc_o=VC always. dt_o and wc_o hold their values until the next strobe.
- Timeout: in WAIT_HS or WAIT_PYLD, a wait of TIMEOUT cycles pulses err_o, drops clk_hs_en_o and txfr_en_o, and returns to IDLE. The pending flags are kept.
- An fv_start_i during STREAM is latched and sent after the current line completes.
- Reset asserted mid-packet: all outputs go to 0 immediately (asynchronous).

Test Plan:
- Reset release with c2d_ready_i=1 and fv_start_i pulse, FRAME_CNT_MAX=2 -> clk_hs_en_o rises; d_hs_en_o pulses 8 cycles later; after d_hs_rdy_i, sp_en_o pulses with dt_o=00 and wc_o=1.
- One line, WC=1920, 240 byte_en_i beats -> lp_en_o pulses with wc_o=1920; txfr_en_o is high after ld_pyld_i and low on beat 240; byte_data_o lags byte_data_i by 1 cycle.
- fv_end_i and txfr_req_i pending together -> long packet sent first, then FE (dt_o=01); clk_hs_en_o stays high between them.
- Three frames with FRAME_CNT_MAX=2 -> FS wc_o sequence is 1, 2, 1.
- d_hs_rdy_i held at 0 -> err_o pulses after 1023 cycles; state returns to IDLE; the retry sends the same FS.
- rst_n_i asserted during STREAM -> all outputs are 0 in the same cycle; after release the block is in IDLE and no flags are pending.
